mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS-subset CPU. Sequences IF/ID/EX/MEM/WB and drives the
//  ALU operand muxes, the 4-bit ALU control code, and the PC/IR/regfile/memory enables.
//  Sits between the IR fields (opcode, funct) and the datapath; ALU zero flag feeds back for beq.
//  Subset: R-type add/sub/and/or/nor/slt, lw, sw, beq, j, addi/andi/ori/slti.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter instret (wraps modulo 2^CNT_W)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  opcode       in   6      IR[31:26]; stable after IF (IR only written in IF)
//  funct        in   6      IR[5:0]
//  zero         in   1      ALU result==0
//  mem_ready    in   1      memory done (present only with MC_MEM_WAIT_EN)
//  pc_we        out  1      PC write
//  pc_src       out  2      00 ALU result, 01 ALUOut (branch target), 10 jump target
//  iord         out  1      0 PC addresses memory, 1 ALUOut
//  mem_rd/mem_wr out 1 each memory read / write strobe
//  ir_we        out  1      IR write
//  reg_dst      out  1      0 rt, 1 rd
//  mem_to_reg   out  1      0 ALUOut, 1 MDR
//  reg_we       out  1      regfile write
//  alu_src_a    out  1      0 PC, 1 reg A
//  alu_src_b    out  2      00 reg B, 01 const 4, 10 imm ext, 11 sign-ext imm<<2
//  ext_zero     out  1      1 zero-extend imm (andi/ori), else sign-extend
//  alu_control  out  4      ALU_* code from macro.vh
//  illegal      out  1      one-cycle pulse: undecodable opcode/funct
//  state        out  4      current state (debug)
//  instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - rst high: state<=IF, instret<=0; all outputs 0 while rst high (no writes during reset).
//  - Moore decode from state (plus opcode/funct); only pc_we in EX_BEQ depends on zero.
//  - States/outputs (unlisted = 0):
//    IF: mem_rd, ir_we, pc_we, src_a=0, src_b=01, ADD, pc_src=00 -> ID
//    ID: src_a=0, src_b=11, ADD -> by opcode: R->EX_R, lw/sw->EX_MEM, beq->EX_BEQ,
//        j->EX_J, addi/andi/ori/slti->EX_I, other->IF with illegal=1
//    EX_R: src_a=1, src_b=00, ctrl from funct (20/22/24/25/27/2A hex); bad funct->IF, illegal=1
//    EX_MEM: src_a=1, src_b=10, ADD -> lw MEM_RD, sw MEM_WR
//    EX_BEQ: src_a=1, src_b=00, SUB, pc_src=01, pc_we=zero -> IF (retire)
//    EX_J: pc_src=10, pc_we=1 -> IF (retire)
//    EX_I: src_a=1, src_b=10, ADD/AND/OR/SLT per opcode, ext_zero for andi/ori -> WB_I
//    MEM_RD: iord, mem_rd -> WB_MEM;  MEM_WR: iord, mem_wr -> IF (retire)
//    WB_MEM: reg_dst=0, mem_to_reg=1, reg_we -> IF;  WB_R: reg_dst=1, reg_we -> IF
//    WB_I: reg_dst=0, reg_we -> IF  (all WB states retire)
//  - Latency: beq/j 3, R/sw/I-arith 4, lw 5 cycles (no memory wait).
//  - instret +1 in the cycle of the retiring state; illegal paths do not retire; wraps to 0.
//  - Unused state encodings -> IF next cycle, no outputs asserted.
// CONFIGURATION
//  MC_MEM_WAIT_EN defined: mem_ready port exists; IF, MEM_RD, MEM_WR hold until mem_ready=1;
//    mem_rd/mem_wr/iord held throughout; pc_we, ir_we asserted and sw retires only in the
//    mem_ready cycle. rst during a wait aborts to IF.
//  Not defined: no mem_ready port; each memory state is exactly one cycle.
// STRUCTURE
//  macro.vh: ALU_* codes, OP_* opcodes, FN_* funct codes, ST_* state encodings (4-bit).
//  Sub-module alu_dec: (funct) -> alu_control, valid; combinational, used in EX_R.
// TESTING
//  1 rst 3 cycles -> all outputs 0; first post-reset cycle state=IF, pc_we=ir_we=mem_rd=1.
//  2 opcode=00,funct=20 -> IF,ID,EX_R(ALU_ADD),WB_R reg_we=reg_dst=1; instret 0->1.
//  3 opcode=23 (lw) -> 5 cycles, MEM_RD iord=1, WB_MEM mem_to_reg=1; opcode=2B sw -> 4, mem_wr.
//  4 opcode=04 beq: zero=1 -> pc_we=1,pc_src=01 in EX_BEQ; zero=0 -> pc_we=0; both retire.
//  5 opcode=3F -> illegal pulse in ID, back to IF, instret unchanged; funct=3F likewise in EX_R.
//  6 MC_MEM_WAIT_EN, mem_ready low 3 cycles in IF -> stay IF, pc_we=0; CNT_W=4, 17 j -> instret=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS-subset control FSM
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IF     = 4'd0,
    ST_ID     = 4'd1,
    ST_EX_R   = 4'd2,
    ST_EX_MEM = 4'd3,
    ST_EX_BEQ = 4'd4,
    ST_EX_J   = 4'd5,
    ST_EX_I   = 4'd6,
    ST_MEM_RD = 4'd7,
    ST_MEM_WR = 4'd8,
    ST_WB_MEM = 4'd9,
    ST_WB_R   = 4'd10,
    ST_WB_I   = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [3:0] alu_control;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// rtl/mc_ctrl_alu_dec.sv - R-type funct to ALU control code decoder
module mc_ctrl_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       valid
);

  always_comb begin
    alu_control = ALU_AND;
    valid       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_NOR:  alu_control = ALU_NOR;
      FN_SLT:  alu_control = ALU_SLT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle IF/ID/EX/MEM/WB control FSM; MC_MEM_WAIT_EN adds mem_ready stalls
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
`ifdef MC_MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_we,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [3:0]       alu_control,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  state_t           cur, nxt;
  ctrl_t            ctrl;
  logic             retire;
  logic             ready;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_alu;
  logic             dec_valid;

`ifdef MC_MEM_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  mc_ctrl_alu_dec u_alu_dec (
    .funct       (funct),
    .alu_control (dec_alu),
    .valid       (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= ST_IF;
      cnt <= '0;
    end else begin
      cur <= nxt;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt    = cur;
    ctrl   = '0;
    retire = 1'b0;
    case (cur)
      ST_IF: begin
        ctrl.mem_rd      = 1'b1;
        ctrl.alu_src_b   = 2'b01;
        ctrl.alu_control = ALU_ADD;
        // PC and IR only commit once the fetch has actually returned
        ctrl.ir_we       = ready;
        ctrl.pc_we       = ready;
        if (ready) nxt = ST_ID;
      end
      ST_ID: begin
        ctrl.alu_src_b   = 2'b11;
        ctrl.alu_control = ALU_ADD;
        case (opcode)
          OP_RTYPE:                         nxt = ST_EX_R;
          OP_LW, OP_SW:                     nxt = ST_EX_MEM;
          OP_BEQ:                           nxt = ST_EX_BEQ;
          OP_J:                             nxt = ST_EX_J;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = ST_EX_I;
          default: begin
            nxt          = ST_IF;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      ST_EX_R: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_control = dec_alu;
        if (dec_valid) begin
          nxt = ST_WB_R;
        end else begin
          nxt          = ST_IF;
          ctrl.illegal = 1'b1;
        end
      end
      ST_EX_MEM: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = 2'b10;
        ctrl.alu_control = ALU_ADD;
        nxt = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_EX_BEQ: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_control = ALU_SUB;
        ctrl.pc_src      = 2'b01;
        ctrl.pc_we       = zero;
        retire           = 1'b1;
        nxt              = ST_IF;
      end
      ST_EX_J: begin
        ctrl.pc_src = 2'b10;
        ctrl.pc_we  = 1'b1;
        retire      = 1'b1;
        nxt         = ST_IF;
      end
      ST_EX_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        case (opcode)
          OP_ANDI: begin ctrl.alu_control = ALU_AND; ctrl.ext_zero = 1'b1; end
          OP_ORI:  begin ctrl.alu_control = ALU_OR;  ctrl.ext_zero = 1'b1; end
          OP_SLTI: ctrl.alu_control = ALU_SLT;
          default: ctrl.alu_control = ALU_ADD;
        endcase
        nxt = ST_WB_I;
      end
      ST_MEM_RD: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_rd = 1'b1;
        if (ready) nxt = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_wr = 1'b1;
        if (ready) begin
          retire = 1'b1;
          nxt    = ST_IF;
        end
      end
      ST_WB_MEM: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_we     = 1'b1;
        retire          = 1'b1;
        nxt             = ST_IF;
      end
      ST_WB_R: begin
        ctrl.reg_dst = 1'b1;
        ctrl.reg_we  = 1'b1;
        retire       = 1'b1;
        nxt          = ST_IF;
      end
      ST_WB_I: begin
        ctrl.reg_we = 1'b1;
        retire      = 1'b1;
        nxt         = ST_IF;
      end
      default: nxt = ST_IF;
    endcase
  end

  // Everything is forced low during reset so no datapath write can slip through
  assign {pc_we, pc_src, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we,
          alu_src_a, alu_src_b, ext_zero, alu_control, illegal} = rst ? '0 : ctrl;
  assign state   = rst ? 4'd0 : cur;
  assign instret = rst ? '0 : cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized instruction-level checks of mc_ctrl against a phase-sequence model
module tb_mc_ctrl;

  localparam int CW = 4;

  localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_EXR = 4'd2, S_EXM = 4'd3, S_EXB = 4'd4,
                         S_EXJ = 4'd5, S_EXI = 4'd6, S_MRD = 4'd7, S_MWR = 4'd8,
                         S_WBM = 4'd9, S_WBR = 4'd10, S_WBI = 4'd11;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                         A_SUB = 4'b0110, A_SLT = 4'b0111, A_NOR = 4'b1100;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [3:0] alu_control;
    logic       illegal;
    logic [3:0] state;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = '0, funct = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we;
  logic          alu_src_a, ext_zero, illegal;
  logic [1:0]    pc_src, alu_src_b;
  logic [3:0]    alu_control, state;
  logic [CW-1:0] instret;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [5:0]    ops[9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0A};
  logic [5:0]    fns[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
`ifdef MC_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_we(pc_we), .pc_src(pc_src), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_we(ir_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_we(reg_we),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .alu_control(alu_control), .illegal(illegal), .state(state), .instret(instret)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic vec_t observed();
    vec_t v;
    v.pc_we = pc_we; v.pc_src = pc_src; v.iord = iord; v.mem_rd = mem_rd; v.mem_wr = mem_wr;
    v.ir_we = ir_we; v.reg_dst = reg_dst; v.mem_to_reg = mem_to_reg; v.reg_we = reg_we;
    v.alu_src_a = alu_src_a; v.alu_src_b = alu_src_b; v.ext_zero = ext_zero;
    v.alu_control = alu_control; v.illegal = illegal; v.state = state;
    return v;
  endfunction

  function automatic logic [3:0] r_alu(logic [5:0] fn);
    case (fn)
      6'h20: return A_ADD;
      6'h22: return A_SUB;
      6'h24: return A_AND;
      6'h25: return A_OR;
      6'h27: return A_NOR;
      6'h2A: return A_SLT;
      default: return A_AND;
    endcase
  endfunction

  function automatic bit r_ok(logic [5:0] fn);
    foreach (fns[i]) if (fns[i] == fn) return 1'b1;
    return 1'b0;
  endfunction

  function automatic vec_t expect_of(logic [3:0] ph, logic [5:0] op, logic [5:0] fn,
                                     logic z, logic rdy, logic bad);
    vec_t v = '0;
    v.state = ph;
    case (ph)
      S_IF:  begin v.mem_rd = 1; v.alu_src_b = 2'b01; v.alu_control = A_ADD;
                   v.ir_we = rdy; v.pc_we = rdy; end
      S_ID:  begin v.alu_src_b = 2'b11; v.alu_control = A_ADD; v.illegal = bad; end
      S_EXR: begin v.alu_src_a = 1; v.alu_control = r_alu(fn); v.illegal = bad; end
      S_EXM: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; v.alu_control = A_ADD; end
      S_EXB: begin v.alu_src_a = 1; v.alu_control = A_SUB; v.pc_src = 2'b01; v.pc_we = z; end
      S_EXJ: begin v.pc_src = 2'b10; v.pc_we = 1; end
      S_EXI: begin
        v.alu_src_a = 1; v.alu_src_b = 2'b10;
        v.alu_control = (op == 6'h0C) ? A_AND : (op == 6'h0D) ? A_OR :
                        (op == 6'h0A) ? A_SLT : A_ADD;
        v.ext_zero = (op == 6'h0C) || (op == 6'h0D);
      end
      S_MRD: begin v.iord = 1; v.mem_rd = 1; end
      S_MWR: begin v.iord = 1; v.mem_wr = 1; end
      S_WBM: begin v.mem_to_reg = 1; v.reg_we = 1; end
      S_WBR: begin v.reg_dst = 1; v.reg_we = 1; end
      S_WBI: v.reg_we = 1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      opcode = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      check("rst_outputs", observed(), '0);
      check("rst_instret", instret, '0);
    end
    exp_cnt = '0;
  endtask

  // Each instruction is a list of phases; memory phases may repeat while mem_ready is low
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic z);
    logic [3:0] phases[$];
    int         bad_at;
    int         waits;
    logic       rdy;
    bit         memph;
    bad_at = -1;
    phases = {S_IF, S_ID};
    if (op == 6'h00) begin
      phases.push_back(S_EXR);
      if (r_ok(fn)) phases.push_back(S_WBR); else bad_at = 2;
    end else if (op == 6'h23) phases = {phases, S_EXM, S_MRD, S_WBM};
    else if (op == 6'h2B) phases = {phases, S_EXM, S_MWR};
    else if (op == 6'h04) phases.push_back(S_EXB);
    else if (op == 6'h02) phases.push_back(S_EXJ);
    else if (op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0A)
      phases = {phases, S_EXI, S_WBI};
    else bad_at = 1;

    foreach (phases[i]) begin
      waits = 0;
      memph = (phases[i] == S_IF) || (phases[i] == S_MRD) || (phases[i] == S_MWR);
      forever begin
        rdy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; opcode = op; funct = fn; zero = z;
`ifdef MC_MEM_WAIT_EN
        if (memph && waits < 4) rdy = ($urandom_range(0, 2) != 0);
        mem_ready = memph ? rdy : 1'($urandom);
`else
        mem_ready = 1'($urandom);
`endif
        @(negedge clk);
        check($sformatf("ctrl op=%0h fn=%0h ph=%0d", op, fn, phases[i]), observed(),
              expect_of(phases[i], op, fn, z, rdy, (i == bad_at)));
        check($sformatf("instret op=%0h ph=%0d", op, phases[i]), instret, exp_cnt);
        if (rdy) break;
        waits++;
      end
      if (i == phases.size() - 1 && bad_at < 0) exp_cnt++;
    end
  endtask

  initial begin
    do_reset();

    run_instr(6'h00, 6'h20, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0);
    run_instr(6'h2B, 6'h00, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1);
    run_instr(6'h04, 6'h00, 1'b0);
    run_instr(6'h3F, 6'h00, 1'b0);
    run_instr(6'h00, 6'h3F, 1'b0);
    run_instr(6'h0C, 6'h00, 1'b0);
    run_instr(6'h0D, 6'h00, 1'b0);
    run_instr(6'h0A, 6'h00, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run_instr(op, fn, 1'($urandom));
      if (n == 75) do_reset();
    end

    do_reset();
    for (int n = 0; n < 17; n++) run_instr(6'h02, 6'($urandom), 1'($urandom));
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("instret_wrap_17j", instret, CW'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
